imem_loader: RTL and testbench

Instruction memory and program loader that sits directly upstream of `datapath`. It accepts a program over a valid/ready byte stream and holds the core in reset while loading. In run mode it returns one 8-bit instruction per clock, addressed by the datapath's `PC`. Instructions use the 2-bit-opcode, 8-bit format consumed by `datapath`.

---
 rtl/imem_loader.sv | 114 +++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Instruction memory with valid/ready program loader; holds the
//             core in reset while loading, then serves one instruction per
//             clock addressed by PC. Optional macro: IMEM_BOUNDS_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              _CLK,
  input  logic              RESET,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [7:0]        PC,
  output logic [7:0]        instruction,
  output logic              core_reset,
  output logic [ADDR_W:0]   count,
  output logic              pc_oor
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_LAST  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ADDR_W:0] r_count;
  logic [7:0]      r_instr;
  logic [7:0]      r_mem [DEPTH];
  logic            w_xfer;
  logic            w_reload;
  logic [7:0]      w_fetch;

  assign load_ready  = (r_state == ST_LOAD) && (r_count < C_DEPTH);
  assign w_xfer      = load_valid && load_ready;
  assign w_reload    = (r_state == ST_RUN) && load_start;
  assign core_reset  = (r_state != ST_RUN);
  assign count       = r_count;
  assign instruction = r_instr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (load_start) w_state_nxt = ST_LOAD;
      // Filling the last slot ends the load even without load_last
      ST_LOAD: if (w_xfer && (load_last || (r_count == C_LAST))) w_state_nxt = ST_RUN;
      ST_RUN:  if (load_start) w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  logic w_oob;
  logic r_oor;

  assign w_oob   = ({1'b0, PC} >= 9'(r_count));
  assign w_fetch = w_oob ? 8'h00 : r_mem[PC[ADDR_W-1:0]];
  assign pc_oor  = r_oor;

  always_ff @(posedge _CLK or posedge RESET) begin
    if (RESET) begin
      r_oor <= 1'b0;
    end else if (w_reload) begin
      r_oor <= 1'b0;
    end else if ((r_state == ST_RUN) && w_oob) begin
      r_oor <= 1'b1;
    end
  end
`else
  logic w_unused_pc;

  // Upper PC bits are intentionally dropped: fetch wraps modulo DEPTH
  assign w_unused_pc = ^PC;
  assign w_fetch     = r_mem[PC[ADDR_W-1:0]];
  assign pc_oor      = 1'b0;
`endif

  always_ff @(posedge _CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_instr <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_reload) begin
        r_count <= '0;
      end else if (w_xfer) begin
        r_count <= r_count + C_ONE;
      end
      r_instr <= ((r_state == ST_RUN) && !load_start) ? w_fetch : 8'h00;
    end
  end

  // Storage is deliberately not reset; count alone defines the valid program
  always_ff @(posedge _CLK) begin
    if (w_xfer) begin
      r_mem[r_count[ADDR_W-1:0]] <= load_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader; directed program scenarios
//             followed by randomized traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic            _CLK       = 1'b0;
  logic            RESET      = 1'b1;
  logic            load_start = 1'b0;
  logic            load_valid = 1'b0;
  logic [7:0]      load_data  = 8'h00;
  logic            load_last  = 1'b0;
  logic [7:0]      PC         = 8'h00;
  logic            load_ready;
  logic [7:0]      instruction;
  logic            core_reset;
  logic [ADDR_W:0] count;
  logic            pc_oor;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_mode;
  int         m_count;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_instr;
  logic       m_oor;
  logic [7:0] full_words [DEPTH];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    ._CLK        (_CLK),
    .RESET       (RESET),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .PC          (PC),
    .instruction (instruction),
    .core_reset  (core_reset),
    .count       (count),
    .pc_oor      (pc_oor)
  );

  always #5 _CLK = ~_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_range(input int pc);
`ifdef IMEM_BOUNDS_CHECK_EN
    return pc < m_count;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] ref_fetch(input int pc);
`ifdef IMEM_BOUNDS_CHECK_EN
    return in_range(pc) ? m_mem[pc] : 8'h00;
`else
    return m_mem[pc % DEPTH];
`endif
  endfunction

  task automatic model_edge();
    bit ready;
    ready = (m_mode == M_LOAD) && (m_count < DEPTH);
    case (m_mode)
      M_IDLE: if (load_start) m_mode = M_LOAD;
      M_LOAD: if (load_valid && ready) begin
        m_mem[m_count] = load_data;
        m_count++;
        if (load_last || m_count == DEPTH) m_mode = M_RUN;
      end
      default: if (load_start) begin
        m_mode = M_LOAD; m_count = 0; m_instr = 8'h00; m_oor = 1'b0;
      end else begin
        m_instr = ref_fetch(int'(PC));
        if (!in_range(int'(PC))) m_oor = 1'b1;
      end
    endcase
  endtask

  task automatic check_outputs();
    chk("instruction", 32'(instruction), 32'(m_instr));
    chk("count", 32'(count), 32'(m_count));
    chk("core_reset", 32'(core_reset), 32'(m_mode != M_RUN));
    chk("load_ready", 32'(load_ready), 32'((m_mode == M_LOAD) && (m_count < DEPTH)));
    chk("pc_oor", 32'(pc_oor), 32'(m_oor));
  endtask

  task automatic step();
    model_edge();
    @(posedge _CLK);
    #1;
    check_outputs();
  endtask

  // Called 1ns after a rising edge; reset asserts mid-cycle and is checked before any edge
  task automatic apply_reset();
    RESET = 1'b1;
    #1;
    m_mode = M_IDLE; m_count = 0; m_instr = 8'h00; m_oor = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_load_ready", 32'(load_ready), 0);
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_instruction", 32'(instruction), 0);
    chk("rst_pc_oor", 32'(pc_oor), 0);
    @(posedge _CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    step();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [6];
    prog = '{8'h71, 8'h4D, 8'h74, 8'hB7, 8'h05, 8'hC2};
    @(posedge _CLK);
    #1;
    apply_reset();

    // Normal six-word load
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 6; i++) send(prog[i], i == 5);
    chk("normal_count", 32'(count), 6);
    chk("normal_core_reset", 32'(core_reset), 0);
    chk("normal_instr_hold", 32'(instruction), 0);

    PC = 8'd3; step(); chk("fetch_pc3", 32'(instruction), 32'h B7);
    PC = 8'd0; step(); chk("fetch_pc0", 32'(instruction), 32'h71);
`ifdef IMEM_BOUNDS_CHECK_EN
    PC = 8'd6; step();
    chk("oob_instr", 32'(instruction), 0);
    chk("oob_flag", 32'(pc_oor), 1);
    PC = 8'd0; step();
    chk("oob_sticky", 32'(pc_oor), 1);
`else
    PC = 8'd33; step();
    chk("wrap_instr", 32'(instruction), 32'h4D);
    chk("wrap_oor", 32'(pc_oor), 0);
    PC = 8'd0; step();
`endif

    // Reload from RUN; a load_start coinciding with a transfer must not disturb it
    load_start = 1'b1; step(); load_start = 1'b0;
    chk("reload_core_reset", 32'(core_reset), 1);
    chk("reload_instr", 32'(instruction), 0);
    chk("reload_count", 32'(count), 0);
    chk("reload_oor", 32'(pc_oor), 0);
    load_start = 1'b1; send(8'h3C, 1'b0); load_start = 1'b0;
    chk("reload_start_in_load", 32'(count), 1);
    send(8'h99, 1'b1);
    PC = 8'd0; step(); chk("reload_word0", 32'(instruction), 32'h3C);

    // Full memory with valid held and no load_last
    apply_reset();
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      full_words[i] = 8'($urandom);
      load_data = full_words[i];
      step();
    end
    chk("full_ready", 32'(load_ready), 0);
    chk("full_count", 32'(count), DEPTH);
    chk("full_run", 32'(core_reset), 0);
    load_data = 8'hEE; step();
    chk("full_no_extra", 32'(count), DEPTH);
    load_valid = 1'b0;
    PC = 8'd31; step(); chk("full_pc31", 32'(instruction), 32'(full_words[31]));
    PC = 8'd0;  step(); chk("full_pc0", 32'(instruction), 32'(full_words[0]));

    // Reset mid-load, then a short reload
    apply_reset();
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    apply_reset();
    load_start = 1'b1; step(); load_start = 1'b0;
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    chk("reload_two", 32'(count), 2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      load_start = ($urandom_range(0, 15) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      load_last  = ($urandom_range(0, 9) == 0);
      load_data  = 8'($urandom);
      PC = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      if ($urandom_range(0, 299) == 0) apply_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
